// File: rtl/imm_pkg.sv
// Shared encodings and the stage-1 payload layout for the immediate-extend pipeline.
package imm_pkg;

  // Immediate source selector as seen on ImmSrc
  typedef enum logic [1:0] {
    IMM_DP  = 2'b00,  // data-processing rotated imm8
    IMM_MEM = 2'b01,  // load/store imm12, zero-extended
    IMM_BR  = 2'b10,  // branch offset, word-aligned and sign-extended
    IMM_UP  = 2'b11   // imm12 placed in the top bits
  } imm_src_e;

  localparam int INSTR_W = 24;

  // Raw request as captured by stage 1; decoding happens on the way into stage 2
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    imm_src_e           mode;
    logic               carry;
  } s1_payload_t;

endpackage

// File: rtl/imm_rotator.sv
// 32-bit rotate-right by an even amount 0..30, with shifter carry-out.
module imm_rotator (
  input  logic [31:0] data_i,
  input  logic [4:0]  amt_i,
  input  logic        carry_i,
  output logic [31:0] result_o,
  output logic        carry_o
);

  // Rotate by shifting a doubled copy; a zero rotate passes the incoming carry through
  always_comb begin
    result_o = 32'({data_i, data_i} >> amt_i);
    carry_o  = (amt_i == 5'd0) ? carry_i : result_o[31];
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Two-stage valid/ready pipeline that extends instruction immediates.
// Stage 1 holds the raw field, stage 2 holds the decoded ExtImm/ShCarry.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ROTATE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [23:0]      Instr,
  input  logic [1:0]       ImmSrc,
  input  logic             CarryIn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ExtImm,
  output logic             ShCarry
);

  logic             s1_valid_q;
  s1_payload_t      s1_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] ext_q;
  logic             shc_q;

  logic             s1_adv;
  logic             s2_adv;
  logic [WIDTH-1:0] ext_d;
  logic             shc_d;
  logic [31:0]      rot_result;
  logic             rot_carry;

  // Stage 2 frees up when empty or retiring; stage 1 when empty or moving on.
  // This makes in_ready combinationally dependent on out_ready.
  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  assign out_valid = s2_valid_q;
  assign ExtImm    = ext_q;
  assign ShCarry   = shc_q;

  imm_rotator u_rot (
    .data_i   ({24'd0, s1_q.instr[7:0]}),
    .amt_i    ({s1_q.instr[11:8], 1'b0}),
    .carry_i  (s1_q.carry),
    .result_o (rot_result),
    .carry_o  (rot_carry)
  );

  // Decode the stage-1 payload into the final immediate and carry
  always_comb begin
    ext_d = '0;
    shc_d = s1_q.carry;
    unique case (s1_q.mode)
      IMM_DP: begin
        if (ROTATE != 0) begin
          ext_d = WIDTH'(rot_result);
          shc_d = rot_carry;
        end else begin
          ext_d = WIDTH'(s1_q.instr[7:0]);
        end
      end
      IMM_MEM: ext_d = WIDTH'(s1_q.instr[11:0]);
      IMM_BR:  ext_d = WIDTH'($signed({s1_q.instr, 2'b00}));
      IMM_UP:  ext_d = WIDTH'(s1_q.instr[11:0]) << (WIDTH - 12);
      default: ext_d = '0;
    endcase
  end

  // Stage 1: capture the raw request whenever the slot can advance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_q       <= '0;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_q <= '{instr: Instr, mode: imm_src_e'(ImmSrc), carry: CarryIn};
      end
    end
  end

  // Stage 2: register the decoded result; held untouched while stalled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid_q <= 1'b0;
      ext_q      <= '0;
      shc_q      <= 1'b0;
    end else if (s2_adv) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        ext_q <= ext_d;
        shc_q <= shc_d;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Bench for imm_extend_pipe: three instances (32-bit rotate, 32-bit no-rotate,
// 64-bit rotate) share one input stream and are checked against a model.
module tb_imm_extend_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [23:0] Instr;
  logic [1:0]  ImmSrc;
  logic        CarryIn;
  logic        out_ready;

  logic        in_ready, out_valid, ShCarry;
  logic [31:0] ExtImm;
  logic        ir_r0, ov_r0, sc_r0;
  logic [31:0] ext_r0;
  logic        ir64, ov64, sc64;
  logic [63:0] ext64;

  int checks = 0;
  int errors = 0;
  int retires = 0;

  typedef struct packed {
    logic [31:0] e32;
    logic        c32;
    logic [31:0] er0;
    logic        cr0;
    logic [63:0] e64;
    logic        c64;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  imm_extend_pipe #(.WIDTH(32), .ROTATE(1)) u_dut (
    .clk(clk), .reset(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .Instr(Instr), .ImmSrc(ImmSrc), .CarryIn(CarryIn), .out_valid(out_valid),
    .out_ready(out_ready), .ExtImm(ExtImm), .ShCarry(ShCarry));

  imm_extend_pipe #(.WIDTH(32), .ROTATE(0)) u_dut_r0 (
    .clk(clk), .reset(reset_n), .in_valid(in_valid), .in_ready(ir_r0),
    .Instr(Instr), .ImmSrc(ImmSrc), .CarryIn(CarryIn), .out_valid(ov_r0),
    .out_ready(out_ready), .ExtImm(ext_r0), .ShCarry(sc_r0));

  imm_extend_pipe #(.WIDTH(64), .ROTATE(1)) u_dut_64 (
    .clk(clk), .reset(reset_n), .in_valid(in_valid), .in_ready(ir64),
    .Instr(Instr), .ImmSrc(ImmSrc), .CarryIn(CarryIn), .out_valid(ov64),
    .out_ready(out_ready), .ExtImm(ext64), .ShCarry(sc64));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: arithmetic reading of the immediate rules
  function automatic exp_t model(input logic [23:0] ins, input logic [1:0] m, input logic c);
    exp_t            r;
    longint unsigned v8, rot;
    longint          off;
    int              amt;
    v8  = longint'(ins[7:0]);
    amt = 2 * int'(ins[11:8]);
    rot = ((v8 >> amt) | (v8 << (32 - amt))) & 64'hFFFF_FFFF;
    off = longint'(ins) * 4;
    if (ins[23]) off = off - (longint'(1) << 26);
    r = '0;
    r.c32 = c;
    r.cr0 = c;
    case (m)
      2'd0: begin
        r.e32 = rot[31:0];
        r.er0 = 32'(ins[7:0]);
        r.e64 = rot;
        if (amt != 0) r.c32 = rot[31];
      end
      2'd1: begin
        r.e32 = 32'(ins[11:0]);
        r.er0 = 32'(ins[11:0]);
        r.e64 = 64'(ins[11:0]);
      end
      2'd2: begin
        r.e32 = off[31:0];
        r.er0 = off[31:0];
        r.e64 = off;
      end
      default: begin
        r.e32 = 32'(ins[11:0]) * 32'h0010_0000;
        r.er0 = 32'(ins[11:0]) * 32'h0010_0000;
        r.e64 = 64'(ins[11:0]) * 64'h0010_0000_0000_0000;
      end
    endcase
    r.c64 = r.c32;
    return r;
  endfunction

  // Monitor: one compare pass per falling edge
  initial begin
    exp_t        e;
    logic        hold_pending;
    logic [31:0] h32, hr0;
    logic [63:0] h64;
    logic        hc32, hcr0, hc64;
    hold_pending = 1'b0;
    {h32, hr0, h64, hc32, hcr0, hc64} = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        q.delete();
        hold_pending = 1'b0;
      end else begin
        if (hold_pending) begin
          chk("stall_valid", 64'(out_valid), 64'd1);
          chk("stall_ext32", 64'(ExtImm), 64'(h32));
          chk("stall_c32", 64'(ShCarry), 64'(hc32));
          chk("stall_ext_r0", 64'(ext_r0), 64'(hr0));
          chk("stall_c_r0", 64'(sc_r0), 64'(hcr0));
          chk("stall_ext64", ext64, h64);
          chk("stall_c64", 64'(sc64), 64'(hc64));
        end
        hold_pending = out_valid && !out_ready;
        h32 = ExtImm; hr0 = ext_r0; h64 = ext64;
        hc32 = ShCarry; hcr0 = sc_r0; hc64 = sc64;

        chk("valid_agree", 64'({ov_r0, ov64, ir_r0, ir64}), 64'({out_valid, out_valid, in_ready, in_ready}));

        if (out_valid && out_ready) begin
          chk("retire_expected", 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            retires++;
            chk("ext32", 64'(ExtImm), 64'(e.e32));
            chk("c32", 64'(ShCarry), 64'(e.c32));
            chk("ext_r0", 64'(ext_r0), 64'(e.er0));
            chk("c_r0", 64'(sc_r0), 64'(e.cr0));
            chk("ext64", ext64, e.e64);
            chk("c64", 64'(sc64), 64'(e.c64));
          end
        end

        if (in_valid && in_ready) q.push_back(model(Instr, ImmSrc, CarryIn));
      end
    end
  end

  // One isolated request with hand-computed expectations, pipeline empty, out_ready high
  task automatic single(input logic [23:0] ins, input logic [1:0] m, input logic c,
                        input logic [31:0] x32, input logic xc,
                        input logic [31:0] xr0, input logic [63:0] x64);
    exp_t mm;
    mm = model(ins, m, c);
    chk("model_e32", 64'(mm.e32), 64'(x32));
    chk("model_e64", mm.e64, x64);
    in_valid = 1'b1; Instr = ins; ImmSrc = m; CarryIn = c;
    #1;
    chk("single_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; Instr = 24'($urandom); ImmSrc = 2'($urandom); CarryIn = 1'($urandom);
    chk("lat1_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("lat2_out_valid", 64'(out_valid), 64'd1);
    chk("lit_ext32", 64'(ExtImm), 64'(x32));
    chk("lit_c32", 64'(ShCarry), 64'(xc));
    chk("lit_ext_r0", 64'(ext_r0), 64'(xr0));
    chk("lit_c_r0", 64'(sc_r0), 64'(c));
    chk("lit_ext64", ext64, x64);
    chk("lit_c64", 64'(sc64), 64'(xc));
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    reset_n = 1'b0; in_valid = 1'b0; Instr = '0; ImmSrc = '0; CarryIn = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_ext32", 64'(ExtImm), 64'd0);
    chk("rst_c32", 64'(ShCarry), 64'd0);
    chk("rst_ext64", ext64, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    // Directed literals
    single(24'h0004FF, 2'd0, 1'b0, 32'hFF00_0000, 1'b1, 32'h0000_00FF, 64'h0000_0000_FF00_0000);
    single(24'h0000A5, 2'd0, 1'b1, 32'h0000_00A5, 1'b1, 32'h0000_00A5, 64'h0000_0000_0000_00A5);
    single(24'h0004A5, 2'd0, 1'b0, 32'hA500_0000, 1'b1, 32'h0000_00A5, 64'h0000_0000_A500_0000);
    single(24'hFFFFFE, 2'd2, 1'b0, 32'hFFFF_FFF8, 1'b0, 32'hFFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFF8);
    single(24'h123FFF, 2'd1, 1'b1, 32'h0000_0FFF, 1'b1, 32'h0000_0FFF, 64'h0000_0000_0000_0FFF);
    single(24'h000ABC, 2'd3, 1'b0, 32'hABC0_0000, 1'b0, 32'hABC0_0000, 64'hABC0_0000_0000_0000);
    single(24'h800000, 2'd2, 1'b1, 32'hFE00_0000, 1'b1, 32'hFE00_0000, 64'hFFFF_FFFF_FE00_0000);
    single(24'h000F01, 2'd0, 1'b0, 32'h0000_0004, 1'b0, 32'h0000_0001, 64'h0000_0000_0000_0004);

    // Back-pressure: three back-to-back requests with out_ready low for four cycles
    base = retires;
    out_ready = 1'b0;
    in_valid = 1'b1; Instr = 24'h000111; ImmSrc = 2'd1; CarryIn = 1'b0;
    @(posedge clk); #1;
    Instr = 24'h000222; ImmSrc = 2'd1;
    @(posedge clk); #1;
    Instr = 24'h000333; ImmSrc = 2'd1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    repeat (4) begin
      @(posedge clk); #1;
      chk("bp_held_in_ready", 64'(in_ready), 64'd0);
      chk("bp_held_valid", 64'(out_valid), 64'd1);
      chk("bp_head_value", 64'(ExtImm), 64'h111);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("bp_retired_three", 64'(retires - base), 64'd3);
    chk("bp_queue_empty", 64'(q.size()), 64'd0);

    // Full throughput with out_ready held high
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; Instr = 24'($urandom); ImmSrc = 2'($urandom); CarryIn = 1'($urandom);
      #1;
      chk("tp_in_ready", 64'(in_ready), 64'd1);
      if (i >= 2) chk("tp_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // Randomized traffic with several back-pressure biases
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 1000; i++) begin
        in_valid  = ($urandom_range(0, 9) < 7);
        out_ready = ($urandom_range(0, 9) < (p == 0 ? 2 : (p == 1 ? 6 : 9)));
        Instr     = 24'($urandom);
        ImmSrc    = 2'($urandom);
        CarryIn   = 1'($urandom);
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_queue_empty", 64'(q.size()), 64'd0);
    chk("drain_out_valid", 64'(out_valid), 64'd0);

    // Reset with both stages occupied
    out_ready = 1'b0;
    in_valid = 1'b1; Instr = 24'h0004FF; ImmSrc = 2'd0; CarryIn = 1'b0;
    @(posedge clk); #1;
    Instr = 24'h123456; ImmSrc = 2'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("mid_full_valid", 64'(out_valid), 64'd1);
    chk("mid_full_in_ready", 64'(in_ready), 64'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ext32", 64'(ExtImm), 64'd0);
    chk("mid_rst_c32", 64'(ShCarry), 64'd0);
    chk("mid_rst_ext64", ext64, 64'd0);
    out_ready = 1'b1;
    @(posedge clk); @(posedge clk); #3;
    reset_n = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("post_rst_no_retire", 64'(out_valid), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 Parameter WIDTH, default 32, extended-immediate width; legal values >= 32.
REQ-002 Parameter ROTATE, default 1; 1 = mode 00 applies ARM rotated immediate, 0 = mode 00 plain zero-extend of imm8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  request present on Instr/ImmSrc/CarryIn.
REQ-006 in_ready  output  1  block accepts the request this cycle.
REQ-007 Instr  input  24  instruction field bits [23:0].
REQ-008 ImmSrc  input  2  mode: 00 data-proc imm, 01 ld/st imm12, 10 branch offset, 11 imm12 upper.
REQ-009 CarryIn  input  1  current C flag, used for rotate carry-out.
REQ-010 out_valid  output  1  ExtImm/ShCarry hold a result.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 ExtImm  output  WIDTH  extended immediate.
REQ-013 ShCarry  output  1  shifter carry-out for mode 00.

Function
REQ-014 Transfer occurs on in_valid&&in_ready (accept) and out_valid&&out_ready (retire).
REQ-015 Two pipeline stages: S1 registers raw field, mode, CarryIn; S2 registers final ExtImm and ShCarry; latency accept-to-out_valid = 2 cycles.
REQ-016 Mode 00, ROTATE=1: value = zero-extended Instr[7:0] rotated right within low 32 bits by 2*Instr[11:8]; bits above 31 are zero.
REQ-017 Mode 00 carry: rotate amount 0 -> ShCarry = CarryIn; otherwise ShCarry = bit 31 of rotated result.
REQ-018 Mode 00, ROTATE=0: ExtImm = zero-extended Instr[7:0], ShCarry = CarryIn.
REQ-019 Mode 01: ExtImm = zero-extended Instr[11:0]; ShCarry = CarryIn.
REQ-020 Mode 10: ExtImm = {Instr[23:0],2'b00} sign-extended from Instr[23] to WIDTH; ShCarry = CarryIn.
REQ-021 Mode 11: ExtImm = Instr[11:0] in bits [WIDTH-1:WIDTH-12], remainder zero; ShCarry = CarryIn.
REQ-022 S2 advances when S2 empty or retiring; S1 advances when S1 empty or moving into S2.
REQ-023 in_ready = !S1_valid || S1 advancing; combinational path out_ready -> in_ready permitted.
REQ-024 Full throughput: one accept and one retire per cycle when out_ready held high.
REQ-025 ExtImm/ShCarry SHALL stay stable while out_valid && !out_ready.
REQ-026 Pipeline full (both stages valid, out_ready low): in_ready = 0, no request dropped or overwritten.
REQ-027 Simultaneous accept and retire with both stages valid: all advance, order preserved.
REQ-028 Results retire strictly in accept order.

Reset
REQ-029 reset low: both stage valids clear immediately; out_valid = 0, ExtImm = 0, ShCarry = 0, in_ready = 1 after deassertion.
REQ-030 Reset mid-operation discards all in-flight requests; no result emitted for them.

Structure
REQ-031 Package imm_pkg holds ImmSrc encodings (IMM_DP, IMM_MEM, IMM_BR, IMM_UP) and S1 payload typedef.
REQ-032 One combinational sub-module imm_rotator: 32-bit rotate-right by 0..30 with carry-out, instantiated in S1->S2 path.

Verification
REQ-033 Mode 00, Instr[11:0]=0x4FF, CarryIn=0 -> 2 cycles later ExtImm=0xFF000000, ShCarry=1.
REQ-034 Mode 00, Instr[11:0]=0x0A5, CarryIn=1 -> ExtImm=0x000000A5, ShCarry=1; same with ROTATE=0, Instr=0x4A5 -> 0x000000A5.
REQ-035 Mode 10, Instr=0xFFFFFE -> ExtImm=0xFFFFFFF8; mode 01, Instr=0x123FFF -> 0x00000FFF; mode 11, Instr[11:0]=0xABC -> 0xABC00000.
REQ-036 Three back-to-back requests, out_ready low 4 cycles -> in_ready low after second accept, third held; out_ready high -> three results in order, no loss.
REQ-037 reset asserted with both stages valid -> out_valid=0, ExtImm=0 same cycle; nothing retires after release.
REQ-038 WIDTH=64, mode 10, Instr=0x800000 -> ExtImm=0xFFFFFFFFFE000000.
